// File: rtl/cnn_seq_ctrl.sv
// Sequencer for a 5x5-image, 3x3-conv, 9->10 fully-connected CNN with argmax output.
// Optional macro CNN_SEQ_RESTART_EN: START while busy (outside FIN) restarts the run.
module cnn_seq_ctrl (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               START,
  input  logic               MAC_STALL,
  input  logic signed [19:0] ACC_IN,
  output logic               MAC_EN,
  output logic               MAC_CLR,
  output logic [4:0]         PIX_IDX,
  output logic [3:0]         FM_RADDR,
  output logic [6:0]         WGT_IDX,
  output logic               FM_WE,
  output logic [3:0]         FM_WADDR,
  output logic               BUSY,
  output logic               DONE,
  output logic [3:0]         OUT
);

  typedef enum logic [2:0] {IDLE, CONV, CONV_WB, FC, FC_CMP, FIN} state_t;

  state_t             r_state, w_nxt;
  logic [1:0]         r_row, r_col, r_ky, r_kx, w_row, w_col, w_ky, w_kx;
  logic [3:0]         r_f, r_k, w_f, w_k;
  logic signed [19:0] r_best, w_best;
  logic [3:0]         r_best_idx, w_best_idx;
  logic               w_launch;
  logic               r_tap_en, r_tap_clr, r_fm_we, r_busy, r_done;
  logic [4:0]         r_pix_idx;
  logic [3:0]         r_fm_raddr, r_fm_waddr, r_out;
  logic [6:0]         r_wgt_idx;

`ifdef CNN_SEQ_RESTART_EN
  assign w_launch = START && (r_state != FIN);
`else
  assign w_launch = START && (r_state == IDLE);
`endif

  always_comb begin
    w_nxt      = r_state;
    w_row      = r_row;
    w_col      = r_col;
    w_ky       = r_ky;
    w_kx       = r_kx;
    w_f        = r_f;
    w_k        = r_k;
    w_best     = r_best;
    w_best_idx = r_best_idx;
    case (r_state)
      CONV: if (!MAC_STALL) begin
        if (r_kx == 2'd2) begin
          w_kx = 2'd0;
          if (r_ky == 2'd2) begin
            w_ky  = 2'd0;
            w_nxt = CONV_WB;
          end else w_ky = r_ky + 2'd1;
        end else w_kx = r_kx + 2'd1;
      end
      CONV_WB: begin
        w_nxt = CONV;
        if (r_col == 2'd2) begin
          w_col = 2'd0;
          if (r_row == 2'd2) begin
            w_row = 2'd0;
            w_nxt = FC;
          end else w_row = r_row + 2'd1;
        end else w_col = r_col + 2'd1;
      end
      FC: if (!MAC_STALL) begin
        if (r_f == 4'd8) begin
          w_f   = 4'd0;
          w_nxt = FC_CMP;
        end else w_f = r_f + 4'd1;
      end
      FC_CMP: begin
        // Strict greater-than keeps the lower class index on ties.
        if (r_k == 4'd0 || ACC_IN > r_best) begin
          w_best     = ACC_IN;
          w_best_idx = r_k;
        end
        if (r_k == 4'd9) w_nxt = FIN;
        else begin
          w_k   = r_k + 4'd1;
          w_nxt = FC;
        end
      end
      FIN:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
    if (w_launch) begin
      w_nxt      = CONV;
      w_row      = 2'd0;
      w_col      = 2'd0;
      w_ky       = 2'd0;
      w_kx       = 2'd0;
      w_f        = 4'd0;
      w_k        = 4'd0;
      w_best     = 20'sd0;
      w_best_idx = 4'd0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_row      <= 2'd0;
      r_col      <= 2'd0;
      r_ky       <= 2'd0;
      r_kx       <= 2'd0;
      r_f        <= 4'd0;
      r_k        <= 4'd0;
      r_best     <= 20'sd0;
      r_best_idx <= 4'd0;
      r_tap_en   <= 1'b0;
      r_tap_clr  <= 1'b0;
      r_fm_we    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pix_idx  <= 5'd0;
      r_fm_raddr <= 4'd0;
      r_fm_waddr <= 4'd0;
      r_wgt_idx  <= 7'd0;
      r_out      <= 4'd0;
    end else begin
      r_state    <= w_nxt;
      r_row      <= w_row;
      r_col      <= w_col;
      r_ky       <= w_ky;
      r_kx       <= w_kx;
      r_f        <= w_f;
      r_k        <= w_k;
      r_best     <= w_best;
      r_best_idx <= w_best_idx;
      r_tap_en   <= (w_nxt == CONV) || (w_nxt == FC);
      r_tap_clr  <= ((w_nxt == CONV) && (w_ky == 2'd0) && (w_kx == 2'd0)) ||
                    ((w_nxt == FC) && (w_f == 4'd0));
      r_fm_we    <= (w_nxt == CONV_WB);
      r_busy     <= (w_nxt != IDLE);
      r_done     <= (w_nxt == FIN);
      if (w_nxt == CONV) begin
        r_pix_idx <= ({3'b0, w_row} + {3'b0, w_ky}) * 5'd5 + {3'b0, w_col} + {3'b0, w_kx};
        r_wgt_idx <= {5'b0, w_ky} * 7'd3 + {5'b0, w_kx};
      end
      if (w_nxt == FC) begin
        r_fm_raddr <= w_f;
        r_wgt_idx  <= 7'd9 + {3'b0, w_k} * 7'd9 + {3'b0, w_f};
      end
      if (w_nxt == CONV_WB) r_fm_waddr <= {2'b0, w_row} * 4'd3 + {2'b0, w_col};
      if (w_nxt == FIN) r_out <= w_best_idx;
    end
  end

  // A stalled tap is not accepted, so the strobes drop in the same cycle.
  assign MAC_EN   = r_tap_en & ~MAC_STALL;
  assign MAC_CLR  = r_tap_clr & ~MAC_STALL;
  assign PIX_IDX  = r_pix_idx;
  assign FM_RADDR = r_fm_raddr;
  assign WGT_IDX  = r_wgt_idx;
  assign FM_WE    = r_fm_we;
  assign FM_WADDR = r_fm_waddr;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign OUT      = r_out;

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Bench for cnn_seq_ctrl: random scores and stalls against a schedule/argmax model.
// Cycle n of a run is the n-th clock period after the START-sampling edge (cycle 0 carries START).
module tb_cnn_seq_ctrl;

  logic               CLK = 1'b0, nRST = 1'b0, START = 1'b0, MAC_STALL = 1'b0;
  logic signed [19:0] ACC_IN = 20'sd0;
  logic               MAC_EN, MAC_CLR, FM_WE, BUSY, DONE;
  logic [4:0]         PIX_IDX;
  logic [3:0]         FM_RADDR, FM_WADDR, OUT;
  logic [6:0]         WGT_IDX;

  int total = 0;
  int bad   = 0;

  cnn_seq_ctrl dut (
    .CLK(CLK), .nRST(nRST), .START(START), .MAC_STALL(MAC_STALL), .ACC_IN(ACC_IN),
    .MAC_EN(MAC_EN), .MAC_CLR(MAC_CLR), .PIX_IDX(PIX_IDX), .FM_RADDR(FM_RADDR),
    .WGT_IDX(WGT_IDX), .FM_WE(FM_WE), .FM_WADDR(FM_WADDR), .BUSY(BUSY), .DONE(DONE), .OUT(OUT)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // tap record: {clr, pix[4:0], raddr[3:0], wgt[6:0]}; conv taps ignore raddr, fc taps ignore pix
  localparam logic [16:0] CV_M = 17'b1_11111_0000_1111111;
  localparam logic [16:0] FC_M = 17'b1_00000_1111_1111111;

  logic [17:0]        exp_q[$];
  logic [16:0]        tap_q[$];
  logic [3:0]         we_q[$];
  int                 done_q[$];
  logic [3:0]         out_q[$];
  logic               busy_a[0:511];
  logic               en_a[0:511];
  logic               clr_a[0:511];
  logic [4:0]         pix_a[0:511];
  logic [6:0]         wgt_a[0:511];
  logic signed [19:0] scores[10];

  // reference model
  task automatic build_exp();
    exp_q.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            exp_q.push_back({1'b0, (ky == 0 && kx == 0), 5'((r + ky) * 5 + c + kx), 4'd0, 7'(ky * 3 + kx)});
    for (int k = 0; k < 10; k++)
      for (int f = 0; f < 9; f++)
        exp_q.push_back({1'b1, (f == 0), 5'd0, 4'(f), 7'(9 + k * 9 + f)});
  endtask

  function automatic int ref_best();
    int b = 0;
    for (int k = 1; k < 10; k++) if (scores[k] > scores[b]) b = k;
    return b;
  endfunction

  // Walk the slot list (taps wait out stalls, write-back/compare slots do not) to find the FIN cycle.
  function automatic int ref_done(input int sa, input int sl);
    int t = 1;
    for (int g = 0; g < 19; g++) begin
      for (int i = 0; i < 9; i++) begin
        while (t >= sa && t < sa + sl) t++;
        t++;
      end
      t++;
    end
    return t;
  endfunction

  task automatic rand_scores(input int lo, input int span);
    for (int k = 0; k < 10; k++) scores[k] = 20'(lo + int'($urandom_range(0, span)));
  endtask

  // driver + monitor: runs budget cycles, answering each final FC tap with the next score
  task automatic do_run(input int sa, input int sl, input int s2a, input int s2l, input int rsta, input int budget);
    int  grp = 0;
    bit  acc_pend = 0;
    done_q.delete(); tap_q.delete(); we_q.delete(); out_q.delete();
    for (int n = 0; n <= budget; n++) begin
      @(posedge CLK); #1;
      START     = (n == 0) || (n >= s2a && n < s2a + s2l);
      MAC_STALL = (n >= sa && n < sa + sl);
      ACC_IN    = acc_pend ? scores[grp % 10] : 20'($urandom);
      if (acc_pend) grp++;
      acc_pend = 0;
      if (n == rsta) begin
        nRST = 1'b0;
        break;
      end
      @(negedge CLK);
      busy_a[n] = BUSY; en_a[n] = MAC_EN; clr_a[n] = MAC_CLR; pix_a[n] = PIX_IDX; wgt_a[n] = WGT_IDX;
      if (MAC_EN) begin
        tap_q.push_back({MAC_CLR, PIX_IDX, FM_RADDR, WGT_IDX});
        if (WGT_IDX >= 7'd9 && FM_RADDR == 4'd8) acc_pend = 1;
      end
      if (FM_WE) we_q.push_back(FM_WADDR);
      if (DONE) begin
        done_q.push_back(n);
        out_q.push_back(OUT);
      end
    end
    START = 1'b0;
    MAC_STALL = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if ({MAC_EN, MAC_CLR, FM_WE, DONE, BUSY} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=00000", {MAC_EN, MAC_CLR, FM_WE, DONE, BUSY});
    end
    total++;
    if ({PIX_IDX, FM_RADDR, WGT_IDX, FM_WADDR, OUT} !== 24'd0) begin
      bad++; $display("FAIL reset_indices got=%h want=0", {PIX_IDX, FM_RADDR, WGT_IDX, FM_WADDR, OUT});
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_nominal();
    rand_scores(-100000, 200000);
    scores[6] = 20'sd200001;
    do_run(-1, 0, -1, 0, -1, 200);
    total++;
    if (done_q.size() !== 1 || done_q[0] !== 191) begin
      bad++; $display("FAIL nominal_done n=%0d cyc=%0d want=191", done_q.size(), done_q[0]);
    end
    total++;
    if (out_q[0] !== 4'd6) begin bad++; $display("FAIL nominal_out got=%0d want=6", out_q[0]); end
    total++;
    if (OUT !== 4'd6) begin bad++; $display("FAIL nominal_out_hold got=%0d want=6", OUT); end
    total++;
    if (busy_a[0] !== 1'b0 || busy_a[1] !== 1'b1 || busy_a[192] !== 1'b0) begin
      bad++; $display("FAIL nominal_busy got=%b%b%b want=010", busy_a[0], busy_a[1], busy_a[192]);
    end
    total++;
    if (tap_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL nominal_tap_count got=%0d want=%0d", tap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [16:0] m;
      m = exp_q[i][17] ? FC_M : CV_M;
      total++;
      if ((tap_q[i] & m) !== exp_q[i][16:0]) begin
        bad++; $display("FAIL nominal_tap[%0d] got=%h want=%h", i, tap_q[i] & m, exp_q[i][16:0]);
      end
    end
    total++;
    if (we_q.size() !== 9) begin bad++; $display("FAIL nominal_we_count got=%0d want=9", we_q.size()); end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (we_q[i] !== 4'(i)) begin bad++; $display("FAIL nominal_waddr[%0d] got=%0d want=%0d", i, we_q[i], i); end
    end
  endtask

  task automatic test_addr();
    logic [4:0] pix_tbl [9] = '{5'd7, 5'd8, 5'd9, 5'd12, 5'd13, 5'd14, 5'd17, 5'd18, 5'd19};
    rand_scores(-50000, 100000);
    do_run(-1, 0, -1, 0, -1, 195);
    for (int i = 0; i < 9; i++) begin
      total++;
      if (tap_q[45 + i][15:11] !== pix_tbl[i] || tap_q[45 + i][6:0] !== 7'(i)) begin
        bad++; $display("FAIL addr_win5[%0d] pix=%0d wgt=%0d want pix=%0d wgt=%0d",
                        i, tap_q[45 + i][15:11], tap_q[45 + i][6:0], pix_tbl[i], i);
      end
      total++;
      if (tap_q[108 + i][6:0] !== 7'(36 + i)) begin
        bad++; $display("FAIL addr_cls3[%0d] wgt=%0d want=%0d", i, tap_q[108 + i][6:0], 36 + i);
      end
    end
  endtask

  task automatic test_stall();
    int eb;
    rand_scores(-50000, 100000);
    eb = ref_best();
    do_run(5, 3, -1, 0, -1, 205);
    total++;
    if (done_q.size() !== 1 || done_q[0] !== 194) begin
      bad++; $display("FAIL stall_done n=%0d cyc=%0d want=194", done_q.size(), done_q[0]);
    end
    for (int n = 5; n < 8; n++) begin
      total++;
      if (en_a[n] !== 1'b0 || clr_a[n] !== 1'b0 || pix_a[n] !== 5'd6 || wgt_a[n] !== 7'd4) begin
        bad++; $display("FAIL stall_hold[%0d] en=%b clr=%b pix=%0d wgt=%0d want en=0 clr=0 pix=6 wgt=4",
                        n, en_a[n], clr_a[n], pix_a[n], wgt_a[n]);
      end
    end
    total++;
    if (en_a[8] !== 1'b1 || pix_a[8] !== 5'd6) begin
      bad++; $display("FAIL stall_resume en=%b pix=%0d want en=1 pix=6", en_a[8], pix_a[8]);
    end
    total++;
    if (tap_q.size() !== 171 || out_q[0] !== 4'(eb)) begin
      bad++; $display("FAIL stall_result taps=%0d out=%0d want taps=171 out=%0d", tap_q.size(), out_q[0], eb);
    end
  endtask

  task automatic test_random_stall();
    for (int it = 0; it < 4; it++) begin
      int sa, sl, ed, eb;
      sa = $urandom_range(1, 190);
      sl = $urandom_range(1, 6);
      rand_scores(-300000, 600000);
      ed = ref_done(sa, sl);
      eb = ref_best();
      do_run(sa, sl, -1, 0, -1, ed + 4);
      total++;
      if (done_q.size() !== 1 || done_q[0] !== ed || out_q[0] !== 4'(eb)) begin
        bad++; $display("FAIL rstall[%0d] at=%0d len=%0d n=%0d cyc=%0d out=%0d want cyc=%0d out=%0d",
                        it, sa, sl, done_q.size(), done_q[0], out_q[0], ed, eb);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        logic [16:0] m;
        m = exp_q[i][17] ? FC_M : CV_M;
        total++;
        if ((tap_q[i] & m) !== exp_q[i][16:0]) begin
          bad++; $display("FAIL rstall_tap[%0d] got=%h want=%h", i, tap_q[i] & m, exp_q[i][16:0]);
        end
      end
    end
  endtask

  task automatic test_tie_negative();
    int idx;
    rand_scores(-1000, 2000);
    scores[2] = 20'sd5000;
    scores[7] = 20'sd5000;
    do_run(-1, 0, -1, 0, -1, 195);
    total++;
    if (out_q[0] !== 4'd2) begin bad++; $display("FAIL tie_out got=%0d want=2", out_q[0]); end
    rand_scores(-100000, 99994);
    idx = $urandom_range(0, 9);
    scores[idx] = -20'sd5;
    do_run(-1, 0, -1, 0, -1, 195);
    total++;
    if (out_q[0] !== 4'(idx)) begin bad++; $display("FAIL neg_out got=%0d want=%0d", out_q[0], idx); end
  endtask

  task automatic test_reset_mid();
    int eb;
    rand_scores(-50000, 100000);
    eb = ref_best();
    do_run(-1, 0, -1, 0, 120, 200);
    #1;
    total++;
    if ({MAC_EN, MAC_CLR, FM_WE, DONE, BUSY, PIX_IDX, FM_RADDR, WGT_IDX, FM_WADDR, OUT} !== 29'd0 ||
        done_q.size() !== 0) begin
      bad++; $display("FAIL midreset_outputs got=%h dones=%0d want=0 dones=0",
                      {MAC_EN, MAC_CLR, FM_WE, DONE, BUSY, PIX_IDX, FM_RADDR, WGT_IDX, FM_WADDR, OUT}, done_q.size());
    end
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b1;
    do_run(-1, 0, -1, 0, -1, 195);
    total++;
    if (done_q.size() !== 1 || done_q[0] !== 191 || out_q[0] !== 4'(eb)) begin
      bad++; $display("FAIL midreset_rerun n=%0d cyc=%0d out=%0d want cyc=191 out=%0d",
                      done_q.size(), done_q[0], out_q[0], eb);
    end
  endtask

  task automatic test_restart();
    int eb;
    rand_scores(-50000, 100000);
    eb = ref_best();
    do_run(-1, 0, 50, 1, -1, 250);
`ifdef CNN_SEQ_RESTART_EN
    total++;
    if (done_q.size() !== 1 || done_q[0] !== 241) begin
      bad++; $display("FAIL restart_done n=%0d cyc=%0d want=241", done_q.size(), done_q[0]);
    end
    total++;
    if (pix_a[51] !== 5'd0 || clr_a[51] !== 1'b1 || tap_q.size() !== 45 + 171) begin
      bad++; $display("FAIL restart_taps pix=%0d clr=%b taps=%0d want pix=0 clr=1 taps=216",
                      pix_a[51], clr_a[51], tap_q.size());
    end
`else
    total++;
    if (done_q.size() !== 1 || done_q[0] !== 191) begin
      bad++; $display("FAIL restart_ignored n=%0d cyc=%0d want=191", done_q.size(), done_q[0]);
    end
    total++;
    if (tap_q.size() !== 171) begin bad++; $display("FAIL restart_taps got=%0d want=171", tap_q.size()); end
`endif
    total++;
    if (out_q[0] !== 4'(eb)) begin bad++; $display("FAIL restart_out got=%0d want=%0d", out_q[0], eb); end
  endtask

  task automatic test_back_to_back();
    int eb;
    rand_scores(-50000, 100000);
    eb = ref_best();
    do_run(-1, 0, 191, 2, -1, 390);
    total++;
    if (done_q.size() !== 2 || done_q[0] !== 191 || done_q[1] !== 383) begin
      bad++; $display("FAIL b2b_done n=%0d c0=%0d c1=%0d want 191,383", done_q.size(), done_q[0], done_q[1]);
    end
    total++;
    if (busy_a[192] !== 1'b0 || busy_a[193] !== 1'b1) begin
      bad++; $display("FAIL b2b_busy got=%b%b want=01", busy_a[192], busy_a[193]);
    end
    total++;
    if (out_q[1] !== 4'(eb) || OUT !== 4'(eb)) begin
      bad++; $display("FAIL b2b_out got=%0d/%0d want=%0d", out_q[1], OUT, eb);
    end
  endtask

  initial begin
    build_exp();
    test_reset();
    test_nominal();
    test_addr();
    test_stall();
    test_random_stall();
    test_tie_negative();
    test_reset_mid();
    test_restart();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_seq_ctrl.md
CNN_SEQ_CTRL -- requirements
Module: cnn_seq_ctrl

Interface
REQ-001 The block SHALL use reset nRST, asynchronous, active-low, and clock CLK.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- START  in  1  begin inference, sampled in IDLE
- MAC_STALL  in  1  datapath hold; tap not accepted this cycle
- ACC_IN  in  20  signed MAC accumulator, valid in the cycle after the final tap of a group
- MAC_EN  out  1  tap issue strobe
- MAC_CLR  out  1  with MAC_EN, load instead of accumulate
- PIX_IDX  out  5  image pixel index 0..24 (5x5 image, row-major)
- FM_RADDR  out  4  feature-map read index 0..8 (FC phase)
- WGT_IDX  out  7  weight index: conv 0..8, FC 9..98
- FM_WE  out  1  feature-map write strobe
- FM_WADDR  out  4  feature-map write index 0..8
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- OUT  out  4  winning class 0..9

Function
REQ-003 The FSM SHALL have states IDLE, CONV, CONV_WB, FC, FC_CMP and FIN.
REQ-004 IDLE->CONV on START=1. Window row r, column c, tap ky/kx and class k SHALL be cleared to 0 on this transition.
REQ-005 CONV SHALL issue one tap per cycle while MAC_STALL=0, with these outputs:
- MAC_EN=1
- PIX_IDX=(r+ky)*5+(c+kx)
- WGT_IDX=ky*3+kx
- MAC_CLR=1 only on tap 0
REQ-006 After tap 8 is issued, CONV SHALL go to CONV_WB. CONV_WB lasts one cycle with FM_WE=1 and FM_WADDR=r*3+c.
- Next state is CONV for the following window (c advances first, then r, over a 3x3 window grid).
- After window 8, next state is FC.
REQ-007 FC SHALL issue one tap per cycle while MAC_STALL=0, with these outputs:
- MAC_EN=1
- FM_RADDR=f
- WGT_IDX=9+k*9+f
- MAC_CLR=1 on f=0
After f=8, FC SHALL go to FC_CMP.
REQ-008 FC_CMP (one cycle) SHALL compare ACC_IN against the stored best score:
- If k=0 or ACC_IN > best (signed, strict), it SHALL store ACC_IN as best and k as best index; ties keep the lower index.
- Next state is FC for k+1, or FIN after k=9.
REQ-009 FIN SHALL last one cycle: DONE=1, OUT=best index, then IDLE.
- OUT SHALL hold its value until the next FIN or reset.
REQ-010 When MAC_STALL=1 in CONV or FC, the block SHALL:
- force MAC_EN=0 and MAC_CLR=0;
- freeze all counters;
- hold PIX_IDX, FM_RADDR and WGT_IDX.
MAC_STALL SHALL be ignored in CONV_WB, FC_CMP and FIN.
REQ-011 With no stalls, DONE SHALL assert exactly 191 cycles after the START-sampling edge:
- 90 cycles CONV/CONV_WB;
- 100 cycles FC/FC_CMP;
- FIN.
REQ-012 FM_WE, MAC_EN, MAC_CLR and DONE SHALL be 0 in every state and cycle not named above.
REQ-013 A START pulse in FIN SHALL be ignored. START held high in IDLE after FIN SHALL launch a new run.

Reset
REQ-014 Asserting nRST SHALL immediately force:
- state=IDLE;
- all counters, best score and best index = 0;
- OUT=0, DONE=0, BUSY=0, MAC_EN=0, MAC_CLR=0, FM_WE=0;
- PIX_IDX=0, FM_RADDR=0, WGT_IDX=0, FM_WADDR=0.
REQ-015 Reset mid-run SHALL abandon the run without a DONE pulse. The first START after release SHALL begin a fresh run.

Configuration
REQ-016 Macro CNN_SEQ_RESTART_EN SHALL control START while BUSY=1:
- Defined: START=1 in any state other than IDLE or FIN SHALL return to CONV with all counters and best cleared; no DONE pulse for the aborted run.
- Not defined: START while BUSY=1 SHALL be ignored.

Verification
REQ-017 Directed scenarios:
- Nominal run, no stall, class 6 ACC_IN largest: DONE at cycle 191, OUT=6, and 9 FM_WE pulses with FM_WADDR 0..8.
- Address check: window r=1,c=2 taps SHALL show PIX_IDX 7,8,9,12,13,14,17,18,19 with WGT_IDX 0..8; class k=3 taps SHALL show WGT_IDX 36..44.
- Stall: MAC_STALL=1 for 3 cycles at conv tap 4 -> MAC_EN low for 3 cycles, indices held, DONE at cycle 194.
- Tie: classes 2 and 7 both equal the maximum -> OUT=2. All scores negative, -5 largest -> OUT selects the -5 class.
- Reset at cycle 120 -> all outputs 0, no DONE. START afterwards -> DONE 191 cycles later.
- START at cycle 50: with CNN_SEQ_RESTART_EN, DONE at cycle 50+191 and PIX_IDX restarts at 0; without it, DONE at cycle 191.
